// File: rtl/mem_initiator.sv
// mem_initiator: requester-side master for a 16x32 single-port memory.
// Accepts read/write commands on a valid/ready handshake, drives the memory
// pins (EN/address/Data_in), collects Data_out qualified by Valid_out and
// returns one response per command (read data or read timeout error).
//
// Optional build macro: MEM_INIT_SCRUB_EN -- after reset, zero-fill every
// memory word before the first command is accepted.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready is combinational)
//   cmd_write/cmd_addr/cmd_data   command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/rsp_err/rsp_write    response payload
//   EN/address/Data_in            memory write enable, address, write data
//   Data_out/Valid_out            memory read data and its qualifier
//   wr_count/rd_count             saturating completed-write / good-read counts
module mem_initiator #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_write,
    output logic              EN,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] Data_out,
    input  logic              Valid_out,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4,
        S_SCRUB = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_write_q, rsp_write_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic accept;
    logic rd_hit;
    logic rd_timeout;

    assign cmd_ready  = (state_q == S_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    // Valid_out before RD_LAT still reflects the previous address, so ignore it.
    assign rd_hit     = (wait_cnt_q >= CNT_W'(RD_LAT)) && Valid_out;
    assign rd_timeout = (wait_cnt_q == CNT_W'(TIMEOUT));

`ifdef MEM_INIT_SCRUB_EN
    logic [ADDR_W-1:0] scrub_cnt_q, scrub_cnt_d;
    logic              scrub_done;
    // The write to the last address is on the pins right now.
    assign scrub_done = en_q && (address_q == {ADDR_W{1'b1}});
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef MEM_INIT_SCRUB_EN
            state_q <= S_SCRUB;
`else
            state_q <= S_IDLE;
`endif
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = cmd_write ? S_WRITE : S_READ;
            S_WRITE: state_d = S_RESP;
            S_READ:  state_d = S_WAIT;
            S_WAIT:  if (rd_hit || rd_timeout) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
`ifdef MEM_INIT_SCRUB_EN
            S_SCRUB: if (scrub_done) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values (registered below)
    always_comb begin
        en_d        = 1'b0;
        address_d   = address_q;
        data_in_d   = data_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_write_d = rsp_write_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        wait_cnt_d  = wait_cnt_q;
`ifdef MEM_INIT_SCRUB_EN
        scrub_cnt_d = scrub_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    address_d   = cmd_addr;
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        // EN is registered, so raise it on the accept edge.
                        en_d      = 1'b1;
                        data_in_d = cmd_data;
                    end
                end
            end
            S_WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end
            S_READ: begin
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (rd_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = Data_out;
                    rsp_err_d   = 1'b0;
                    if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                end else if (rd_timeout) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
`ifdef MEM_INIT_SCRUB_EN
            S_SCRUB: begin
                // One zero write per cycle, addresses ascending from 0.
                if (!scrub_done) begin
                    en_d        = 1'b1;
                    address_d   = scrub_cnt_q;
                    data_in_d   = '0;
                    scrub_cnt_d = scrub_cnt_q + ADDR_W'(1);
                end
            end
`endif
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            address_q   <= '0;
            data_in_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_write_q <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            wait_cnt_q  <= '0;
`ifdef MEM_INIT_SCRUB_EN
            scrub_cnt_q <= '0;
`endif
        end else begin
            en_q        <= en_d;
            address_q   <= address_d;
            data_in_q   <= data_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_write_q <= rsp_write_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            wait_cnt_q  <= wait_cnt_d;
`ifdef MEM_INIT_SCRUB_EN
            scrub_cnt_q <= scrub_cnt_d;
`endif
        end
    end

    assign EN        = en_q;
    assign address   = address_q;
    assign Data_in   = data_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_write = rsp_write_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed testbench for mem_initiator with a behavioural 16x32 memory
// (one-cycle registered read, Valid_out high on cycles that were not writes).
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_write;
    logic [31:0] rsp_data;
    logic        EN;
    logic [3:0]  address;
    logic [31:0] Data_in, Data_out;
    logic        Valid_out;
    logic [15:0] wr_count, rd_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    logic        mem_valid_q;
    logic        force_invalid;

    always #5 clk = ~clk;

    mem_initiator dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_write(rsp_write),
        .EN(EN), .address(address), .Data_in(Data_in),
        .Data_out(Data_out), .Valid_out(Valid_out),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    // Memory model
    always @(posedge clk) begin
        if (EN) mem[address] <= Data_in;
        Data_out    <= mem[address];
        mem_valid_q <= !EN;
    end
    assign Valid_out = mem_valid_q && !force_invalid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command with rsp_ready high; lat counts cycles from accept to rsp_valid.
    task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output logic rw,
                          output int lat, output int en_cnt, output logic ok);
        int n;
        ok = 1'b1; lat = 0; en_cnt = 0; rd = '0; er = 1'b0; rw = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) begin ok = 1'b0; return; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        if (EN) en_cnt++;
        while (!rsp_valid && lat < 40) begin
            tick(); lat++;
            if (EN) en_cnt++;
        end
        if (!rsp_valid) begin ok = 1'b0; return; end
        rd = rsp_data; er = rsp_err; rw = rsp_write;
        tick();
    endtask

    task automatic test_reset();
        int n;
        int stray;
        logic exp_ready;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b1; force_invalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        // Start a read and reset it mid-flight.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
`ifdef MEM_INIT_SCRUB_EN
        exp_ready = 1'b0;
`else
        exp_ready = 1'b1;
`endif
        checks++; if (EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", EN); end
        checks++; if (address !== 4'd0) begin errors++; $display("FAIL reset_address: got %0d want 0", address); end
        checks++; if (Data_in !== 32'd0) begin errors++; $display("FAIL reset_data_in: got %h want 0", Data_in); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0 || rsp_write !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags: got err=%b wr=%b want 0 0", rsp_err, rsp_write); end
        checks++; if (wr_count !== 16'd0 || rd_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got wr=%0d rd=%0d want 0 0", wr_count, rd_count); end
        checks++; if (cmd_ready !== exp_ready) begin errors++; $display("FAIL reset_cmd_ready: got %b want %b", cmd_ready, exp_ready); end
        stray = 0;
        repeat (10) begin tick(); if (rsp_valid !== 1'b0) stray++; end
        checks++; if (stray != 0) begin errors++; $display("FAIL reset_stray_rsp: got %0d rsp_valid cycles want 0", stray); end
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, rw, ok; int lat, enc;
        do_cmd(1'b1, 4'd5, 32'hDEADBEEF, rd, er, rw, lat, enc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_done: got no response want response"); end
        checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++; if (enc != 1) begin errors++; $display("FAIL wr_en_cycles: got %0d want 1", enc); end
        checks++; if (rw !== 1'b1 || er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL wr_rsp: got wr=%b err=%b data=%h want 1 0 0", rw, er, rd); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_next_ready: got %b want 1", cmd_ready); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count1: got %0d want 1", wr_count); end
        do_cmd(1'b0, 4'd5, 32'h0, rd, er, rw, lat, enc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_done: got no response want response"); end
        checks++; if (lat != 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data5: got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0 || rw !== 1'b0 || enc != 0) begin errors++; $display("FAIL rd_flags: got err=%b wr=%b en=%0d want 0 0 0", er, rw, enc); end
        checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL rd_count1: got %0d want 1", rd_count); end
    endtask

    task automatic test_sweep();
        logic [31:0] rd; logic er, rw, ok; int lat, enc;
        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b1, 4'(i), 32'h1000_0000 + 32'(i), rd, er, rw, lat, enc, ok);
            checks++; if (!ok || enc != 1) begin errors++; $display("FAIL sweep_wr%0d: got ok=%b en=%0d want 1 1", i, ok, enc); end
        end
        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b0, 4'(i), 32'h0, rd, er, rw, lat, enc, ok);
            checks++; if (rd !== 32'h1000_0000 + 32'(i) || er !== 1'b0) begin errors++; $display("FAIL sweep_rd%0d: got %h err=%b want %h 0", i, rd, er, 32'h1000_0000 + 32'(i)); end
        end
        do_cmd(1'b0, 4'd15, 32'h0, rd, er, rw, lat, enc, ok);
        checks++; if (rd !== 32'h1000_000F) begin errors++; $display("FAIL wrap_rd15: got %h want 1000000f", rd); end
        do_cmd(1'b0, 4'd0, 32'h0, rd, er, rw, lat, enc, ok);
        checks++; if (rd !== 32'h1000_0000) begin errors++; $display("FAIL wrap_rd0: got %h want 10000000", rd); end
        checks++; if (wr_count !== 16'd17 || rd_count !== 16'd19) begin errors++; $display("FAIL sweep_counts: got wr=%0d rd=%0d want 17 19", wr_count, rd_count); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er, rw, ok; int lat, enc;
        force_invalid = 1'b1;
        do_cmd(1'b0, 4'd3, 32'h0, rd, er, rw, lat, enc, ok);
        force_invalid = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL to_done: got no response want response"); end
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL to_rsp: got err=%b data=%h want 1 0", er, rd); end
        checks++; if (lat != 11) begin errors++; $display("FAIL to_latency: got %0d want 11", lat); end
        checks++; if (rd_count !== 16'd19) begin errors++; $display("FAIL to_rd_count: got %0d want 19", rd_count); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] rd, held; logic er, rw, ok; int lat, enc, n, bad;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        held = rsp_data;
        checks++; if (rsp_valid !== 1'b1 || held !== 32'h1000_0005) begin errors++; $display("FAIL bp_rsp: got valid=%b data=%h want 1 10000005", rsp_valid, held); end
        bad = 0;
        // Offer a write during the stall; it must wait, not be lost.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd7; cmd_data = 32'hA5A5_0007;
        repeat (20) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || EN !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stall: got %0d bad cycles want 0", bad); end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", cmd_ready, rsp_valid); end
        do_cmd(1'b1, 4'd6, 32'h0BAD_CAFE, rd, er, rw, lat, enc, ok);
        checks++; if (!ok || lat != 2) begin errors++; $display("FAIL bp_next_cmd: got ok=%b lat=%0d want 1 2", ok, lat); end
        do_cmd(1'b0, 4'd6, 32'h0, rd, er, rw, lat, enc, ok);
        checks++; if (rd !== 32'h0BAD_CAFE) begin errors++; $display("FAIL bp_readback: got %h want 0badcafe", rd); end
        checks++; if (wr_count !== 16'd18 || rd_count !== 16'd21) begin errors++; $display("FAIL final_counts: got wr=%0d rd=%0d want 18 21", wr_count, rd_count); end
    endtask

`ifdef MEM_INIT_SCRUB_EN
    task automatic test_scrub();
        logic [31:0] rd; logic er, rw, ok; int lat, enc, n, nwr, bad;
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n = 0; nwr = 0; bad = 0;
        while (!cmd_ready && n < 40) begin
            if (EN) begin
                if (address !== 4'(nwr) || Data_in !== 32'd0) bad++;
                nwr++;
            end
            tick(); n++;
        end
        checks++; if (nwr != 16 || bad != 0) begin errors++; $display("FAIL scrub_writes: got %0d writes %0d bad want 16 0", nwr, bad); end
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL scrub_wr_count: got %0d want 0", wr_count); end
        do_cmd(1'b0, 4'd9, 32'h0, rd, er, rw, lat, enc, ok);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL scrub_rd9: got %h want 0", rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_sweep();
        test_timeout();
        test_back_pressure();
`ifdef MEM_INIT_SCRUB_EN
        test_scrub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Requester-side master for the 16x32 single-port memory. It accepts read/write commands on a valid/ready handshake, drives the memory's EN/address/Data_in pins, and collects Data_out when Valid_out is high.
- Returns one response per command, carrying read data or a timeout error.
- Sits between the verification/stimulus layer (or a future CPU port) and the memory instance, replacing direct pin wiggling.

Parameters:
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 32, memory data width
- RD_LAT, 1, cycles from read address presented to earliest Data_out sample
- TIMEOUT, 8, max cycles waited for Valid_out before error response (must be > RD_LAT)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  target address
- cmd_data  input  DATA_W  write data (ignored for reads)
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_data  output  DATA_W  read data; 0 for writes and errors
- rsp_err  output  1  1 = read timed out
- rsp_write  output  1  echo of cmd_write
- EN  output  1  memory write enable: 1 = write Data_in to address this cycle
- address  output  ADDR_W  memory address
- Data_in  output  DATA_W  memory write data
- Data_out  input  DATA_W  memory read data
- Valid_out  input  1  memory read data valid
- wr_count  output  16  writes completed, saturating
- rd_count  output  16  successful reads completed, saturating

Behaviour:
- Memory protocol (decided):
  - EN=1 for one cycle writes Data_in to mem[address].
  - With EN=0, the memory returns mem[address] on Data_out, qualified by Valid_out.
- All outputs are registered except cmd_ready, which is high iff state == IDLE.
- Reset (rst=1 at posedge, including mid-transaction):
  - state=IDLE; EN=0, address=0, Data_in=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, rsp_write=0.
  - counters=0, wait counter=0.
  - Any in-flight command is dropped and no response is issued.
- States:
  - IDLE: cmd_ready=1. On accept, latch cmd_*. Write -> WRITE; read -> READ.
  - WRITE: EN=1, address/Data_in = latched values for exactly one cycle -> RESP with rsp_write=1, rsp_data=0, rsp_err=0; wr_count += 1.
  - READ: EN=0, address held at latched value; wait counter cleared -> WAIT.
  - WAIT: wait counter increments each cycle.
    - If counter >= RD_LAT and Valid_out=1: capture Data_out into rsp_data, rsp_err=0, rd_count += 1 -> RESP.
    - Else if counter == TIMEOUT: rsp_data=0, rsp_err=1 -> RESP.
    - Valid_out is ignored while counter < RD_LAT (stale data from the previous address).
  - RESP: rsp_valid=1, rsp_* held stable until rsp_ready=1; on handshake rsp_valid=0 next cycle -> IDLE.
- EN is 0 in every state except WRITE.
- address holds its last value outside transactions.
- Latency with rsp_ready tied high:
  - Write: accept at cycle N, EN at N+1, rsp_valid at N+2, next accept at N+3.
  - Read (RD_LAT=1, Valid_out prompt): rsp_valid at N+4.
- One outstanding command at a time; no pipelining.
- cmd_valid while cmd_ready=0 is held off; the command is not lost.
- Counters saturate at 16'hFFFF and never wrap. Timeouts do not increment rd_count.
- Back-pressure: rsp_ready low indefinitely stalls the block in RESP with no memory activity.

Optional Feature:
- Macro: MEM_INIT_SCRUB_EN.
- Defined: after reset the block enters SCRUB instead of IDLE.
  - Issues 2**ADDR_W consecutive single-cycle writes: EN=1, Data_in=0, address 0..15, one per cycle.
  - cmd_ready=0 throughout SCRUB; enters IDLE the cycle after the write to address 15.
  - Scrub writes do not count in wr_count.
  - rst asserted during SCRUB restarts the scrub at address 0.
- Not defined: no SCRUB state; IDLE directly after reset.

Test Plan:
- Reset: hold rst 10 cycles mid-read, release -> all outputs 0, cmd_ready=1 (after scrub if enabled), no stray rsp_valid.
- Write then read: write addr 5 = 32'hDEADBEEF, read addr 5 -> rsp_data=32'hDEADBEEF, rsp_err=0, wr_count=1, rd_count=1, EN high for exactly one cycle.
- Full sweep: write addr i = 32'h1000_0000+i for i=0..15, then read all 16 -> each matches; address 15 followed by 0 with no aliasing.
- Timeout: force Valid_out=0 on read of addr 3 -> rsp_err=1 and rsp_data=0 after TIMEOUT cycles; rd_count unchanged.
- Back-pressure: rsp_ready low for 20 cycles after a read -> rsp_valid and rsp_data stable, cmd_ready=0, EN=0; release -> next command accepted 1 cycle after handshake.
- MEM_INIT_SCRUB_EN: preload memory with 32'hFFFFFFFF, reset -> 16 zero writes observed, cmd_ready=0 for 16 cycles, subsequent read of addr 9 returns 0.
